// File: rtl/cache_pkg.sv
// Shared types and PLRU tree index helpers for the N-way cache controller.
// Tree nodes are heap-numbered: node i has children 2i+1 (left) and 2i+2 (right).
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WB,
        FILL,
        FINISH
    } cc_state_e;

    // Depth of heap node n (root is level 0).
    function automatic int node_level(input int n);
        int lvl = 0;
        for (int l = 0; l < 8; l++) begin
            if (n >= (1 << (l + 1)) - 1) lvl = l + 1;
        end
        return lvl;
    endfunction

    // Position of heap node n within its level, counted from the left.
    function automatic int node_offset(input int n);
        return n - ((1 << node_level(n)) - 1);
    endfunction

    // Node visited at level l on the root-to-leaf path of way w.
    function automatic int path_node(input int w, input int l, input int widx);
        return (1 << l) - 1 + (w >> (widx - l));
    endfunction

    // True when the path of way w turns right below its level-l node.
    function automatic bit path_right(input int w, input int l, input int widx);
        return ((w >> (widx - 1 - l)) & 1) != 0;
    endfunction

    // Encoder for a one-hot way vector of up to 8 ways.
    function automatic logic [2:0] oh_to_idx(input logic [7:0] oh);
        return {|(oh & 8'hF0), |(oh & 8'hCC), |(oh & 8'hAA)};
    endfunction

endpackage

// File: rtl/plru_tree.sv
// Combinational tree pseudo-LRU: victim walk and touch update for one set.
// A node bit of 0 means the victim lies in its left subtree.
module plru_tree
    import cache_pkg::*;
#(
    parameter int WAYS = 4,
    localparam int WIDX = $clog2(WAYS)
) (
    input  logic [WAYS-2:0] plru_i,
    input  logic [WIDX-1:0] touch_way_i,
    output logic [WIDX-1:0] victim_o,
    output logic [WAYS-2:0] plru_o
);

    logic [WAYS-1:0] leaf_sel;

    // A leaf is the victim when every node on its path steers toward it.
    for (genvar w = 0; w < WAYS; w++) begin : g_leaf
        logic [WIDX-1:0] match;
        for (genvar l = 0; l < WIDX; l++) begin : g_lvl
            localparam int N = path_node(w, l, WIDX);
            if (path_right(w, l, WIDX)) begin : g_r
                assign match[l] = plru_i[N];
            end else begin : g_l
                assign match[l] = ~plru_i[N];
            end
        end
        assign leaf_sel[w] = &match;
    end

    assign victim_o = WIDX'(oh_to_idx(8'(leaf_sel)));

    // Nodes on the touched way's path point away from it; the rest keep their value.
    for (genvar n = 0; n < WAYS - 1; n++) begin : g_node
        localparam int L   = node_level(n);
        localparam int OFF = node_offset(n);
        logic on_path;
        assign on_path   = ((touch_way_i >> (WIDX - L)) == WIDX'(OFF));
        assign plru_o[n] = on_path ? ~touch_way_i[WIDX-1-L] : plru_i[n];
    end

endmodule

// File: rtl/cache_control_nway.sv
// Control FSM for an N-way set-associative write-back, write-allocate cache.
// Only the state and the chosen victim way are flopped; all outputs decode from them.
module cache_control_nway
    import cache_pkg::*;
#(
    parameter int WAYS = 4,
    localparam int WIDX = $clog2(WAYS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [WAYS-1:0] hit_vec,
    input  logic [WAYS-1:0] valid_vec,
    input  logic [WAYS-1:0] dirty_vec,
    input  logic [WAYS-2:0] plru_in,
    input  logic            pmem_resp,
    output logic            pmem_read,
    output logic            pmem_write,
    output logic [WIDX-1:0] way_sel,
    output logic            wb_addr_sel,
    output logic            data_sel,
    output logic [WAYS-1:0] ld_data,
    output logic [WAYS-1:0] ld_tag,
    output logic [WAYS-1:0] ld_valid,
    output logic            valid_in,
    output logic [WAYS-1:0] ld_dirty,
    output logic            dirty_in,
    output logic            ld_plru,
    output logic [WAYS-2:0] plru_out,
    output logic            mem_resp
);

    cc_state_e       state_q, state_d;
    logic [WIDX-1:0] victim_q, victim_d;

    logic            req, hit, miss_needs_wb;
    logic [WAYS-1:0] hit_first, inv_first, victim_oh;
    logic [WIDX-1:0] hit_way, inv_way, plru_victim, miss_victim, touch_way;
    logic [WAYS-2:0] plru_touched;

    assign req       = mem_read | mem_write;
    assign hit       = |hit_vec;
    assign hit_first = hit_vec & (~hit_vec + WAYS'(1));
    // Lowest clear bit of valid_vec: an empty way is always filled before evicting.
    assign inv_first = ~valid_vec & (valid_vec + WAYS'(1));
    assign hit_way   = WIDX'(oh_to_idx(8'(hit_first)));
    assign inv_way   = WIDX'(oh_to_idx(8'(inv_first)));

    assign miss_victim   = (|inv_first) ? inv_way : plru_victim;
    assign miss_needs_wb = dirty_vec[miss_victim] & valid_vec[miss_victim];
    assign victim_oh     = WAYS'(1) << victim_q;
    assign touch_way     = (state_q == FINISH) ? victim_q : hit_way;

    plru_tree #(.WAYS(WAYS)) u_plru (
        .plru_i      (plru_in),
        .touch_way_i (touch_way),
        .victim_o    (plru_victim),
        .plru_o      (plru_touched)
    );

    // NOTE: every variable driven here gets a default first, otherwise a path that skips it infers a latch.
    always_comb begin
        state_d  = state_q;
        victim_d = victim_q;
        case (state_q)
            IDLE:   if (req) state_d = LOOKUP;
            LOOKUP: begin
                if (!req) begin
                    state_d = IDLE;
                end else if (!hit) begin
                    victim_d = miss_victim;
                    state_d  = miss_needs_wb ? WB : FILL;
                end
            end
            WB:     if (pmem_resp) state_d = FILL;
            FILL:   if (pmem_resp) state_d = FINISH;
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pmem_read   = 1'b0;
        pmem_write  = 1'b0;
        way_sel     = '0;
        wb_addr_sel = 1'b0;
        data_sel    = 1'b0;
        ld_data     = '0;
        ld_tag      = '0;
        ld_valid    = '0;
        valid_in    = 1'b0;
        ld_dirty    = '0;
        dirty_in    = 1'b0;
        ld_plru     = 1'b0;
        plru_out    = '0;
        mem_resp    = 1'b0;
        case (state_q)
            LOOKUP: begin
                if (req && hit) begin
                    mem_resp = 1'b1;
                    way_sel  = hit_way;
                    ld_plru  = 1'b1;
                    plru_out = plru_touched;
                    if (mem_write) begin
                        ld_data  = hit_first;
                        ld_dirty = hit_first;
                        dirty_in = 1'b1;
                    end
                end else if (req) begin
                    way_sel = miss_victim;
                end
            end
            WB: begin
                pmem_write  = 1'b1;
                wb_addr_sel = 1'b1;
                way_sel     = victim_q;
                if (pmem_resp) ld_dirty = victim_oh;
            end
            FILL: begin
                pmem_read = 1'b1;
                way_sel   = victim_q;
                if (pmem_resp) begin
                    ld_data  = victim_oh;
                    data_sel = 1'b1;
                    ld_tag   = victim_oh;
                    ld_valid = victim_oh;
                    valid_in = 1'b1;
                    ld_dirty = victim_oh;
                end
            end
            FINISH: begin
                mem_resp = 1'b1;
                way_sel  = victim_q;
                ld_plru  = 1'b1;
                plru_out = plru_touched;
                if (mem_write) begin
                    ld_data  = victim_oh;
                    ld_dirty = victim_oh;
                    dirty_in = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            victim_q <= '0;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
        end
    end

    hit_onehot_a: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == LOOKUP && req) |-> $onehot0(hit_vec));

endmodule

// File: tb/tb_cache_control_nway.sv
// Directed bench for cache_control_nway: WAYS=4 main instance plus WAYS=2/8 for back-to-back hits.
module tb_cache_control_nway;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int wr_high = 0;
    int ld_seen = 0;

    logic rst_n, mem_read, mem_write, pmem_resp;

    logic [3:0] hit_vec, valid_vec, dirty_vec;
    logic [2:0] plru_in;
    logic       pmem_read, pmem_write, wb_addr_sel, data_sel, valid_in, dirty_in, ld_plru, mem_resp;
    logic [1:0] way_sel;
    logic [3:0] ld_data, ld_tag, ld_valid, ld_dirty;
    logic [2:0] plru_out;

    logic [1:0] hit2, valid2, dirty2;
    logic [0:0] plru2, way_sel2, plru_out2;
    logic       pmem_read2, pmem_write2, wb_addr_sel2, data_sel2, valid_in2, dirty_in2, ld_plru2, mem_resp2;
    logic [1:0] ld_data2, ld_tag2, ld_valid2, ld_dirty2;

    logic [7:0] hit8, valid8, dirty8;
    logic [6:0] plru8, plru_out8;
    logic [2:0] way_sel8;
    logic       pmem_read8, pmem_write8, wb_addr_sel8, data_sel8, valid_in8, dirty_in8, ld_plru8, mem_resp8;
    logic [7:0] ld_data8, ld_tag8, ld_valid8, ld_dirty8;

    cache_control_nway #(.WAYS(4)) dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .hit_vec(hit_vec), .valid_vec(valid_vec), .dirty_vec(dirty_vec), .plru_in(plru_in),
        .pmem_resp(pmem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write), .way_sel(way_sel),
        .wb_addr_sel(wb_addr_sel), .data_sel(data_sel), .ld_data(ld_data), .ld_tag(ld_tag),
        .ld_valid(ld_valid), .valid_in(valid_in), .ld_dirty(ld_dirty), .dirty_in(dirty_in),
        .ld_plru(ld_plru), .plru_out(plru_out), .mem_resp(mem_resp)
    );

    cache_control_nway #(.WAYS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .hit_vec(hit2), .valid_vec(valid2), .dirty_vec(dirty2), .plru_in(plru2),
        .pmem_resp(pmem_resp), .pmem_read(pmem_read2), .pmem_write(pmem_write2), .way_sel(way_sel2),
        .wb_addr_sel(wb_addr_sel2), .data_sel(data_sel2), .ld_data(ld_data2), .ld_tag(ld_tag2),
        .ld_valid(ld_valid2), .valid_in(valid_in2), .ld_dirty(ld_dirty2), .dirty_in(dirty_in2),
        .ld_plru(ld_plru2), .plru_out(plru_out2), .mem_resp(mem_resp2)
    );

    cache_control_nway #(.WAYS(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .hit_vec(hit8), .valid_vec(valid8), .dirty_vec(dirty8), .plru_in(plru8),
        .pmem_resp(pmem_resp), .pmem_read(pmem_read8), .pmem_write(pmem_write8), .way_sel(way_sel8),
        .wb_addr_sel(wb_addr_sel8), .data_sel(data_sel8), .ld_data(ld_data8), .ld_tag(ld_tag8),
        .ld_valid(ld_valid8), .valid_in(valid_in8), .ld_dirty(ld_dirty8), .dirty_in(dirty_in8),
        .ld_plru(ld_plru8), .plru_out(plru_out8), .mem_resp(mem_resp8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One back-to-back hit cycle across all three associativities.
    task automatic b2b_hit(input string tag,
                           input logic [3:0] h4, input logic [1:0] h2, input logic [7:0] h8,
                           input logic [1:0] w4, input logic [0:0] w2, input logic [2:0] w8,
                           input logic [2:0] p4, input logic [0:0] p2, input logic [6:0] p8);
        hit_vec = h4;
        hit2    = h2;
        hit8    = h8;
        #1;
        check({tag, "_resp4"}, {mem_resp, ld_plru, way_sel, plru_out}, {1'b1, 1'b1, w4, p4});
        check({tag, "_resp2"}, {mem_resp2, ld_plru2, way_sel2, plru_out2}, {1'b1, 1'b1, w2, p2});
        check({tag, "_resp8"}, {mem_resp8, ld_plru8, way_sel8, plru_out8}, {1'b1, 1'b1, w8, p8});
        check({tag, "_quiet2"}, {pmem_read2, pmem_write2, wb_addr_sel2, data_sel2, ld_data2,
                                 ld_tag2, ld_valid2, valid_in2, ld_dirty2, dirty_in2}, 32'h0);
        check({tag, "_quiet8"}, {pmem_read8, pmem_write8, wb_addr_sel8, data_sel8, valid_in8,
                                 dirty_in8, ld_data8, ld_tag8, ld_valid8}, 32'h0);
        check({tag, "_quiet8d"}, {24'h0, ld_dirty8}, 32'h0);
        tick();
    endtask

    initial begin
        rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
        hit_vec = '0; valid_vec = 4'b1111; dirty_vec = '0; plru_in = '0;
        hit2 = '0; valid2 = 2'b11; dirty2 = '0; plru2 = '0;
        hit8 = '0; valid8 = 8'hFF; dirty8 = '0; plru8 = '0;
        #2;
        check("reset_outputs", {pmem_read, pmem_write, mem_resp, ld_plru, wb_addr_sel, data_sel,
                                ld_data, ld_tag, ld_valid, ld_dirty, way_sel}, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;

        // Read hit on way 2.
        mem_read = 1'b1; hit_vec = 4'b0100; plru_in = 3'b000;
        #1;
        check("idle_no_resp", {31'h0, mem_resp}, 32'h0);
        tick();
        check("rhit_resp", {mem_resp, ld_plru, way_sel, plru_out}, {1'b1, 1'b1, 2'd2, 3'b100});
        check("rhit_no_ld", {ld_data, ld_dirty, ld_tag}, 32'h0);
        mem_read = 1'b0; hit_vec = '0;
        tick();
        check("rhit_after_quiet", {mem_resp, ld_plru}, 32'h0);
        tick();

        // Write hit on way 1.
        mem_write = 1'b1; hit_vec = 4'b0010;
        tick();
        check("whit_loads", {mem_resp, ld_data, ld_dirty, dirty_in, data_sel, plru_out},
              {1'b1, 4'b0010, 4'b0010, 1'b1, 1'b0, 3'b001});
        mem_write = 1'b0; hit_vec = '0;
        tick();
        tick();

        // Read miss fills the lowest invalid way even though it is marked dirty.
        mem_read = 1'b1; valid_vec = 4'b1011; dirty_vec = 4'b1111;
        tick();
        check("rmiss_lookup", {mem_resp, pmem_write, pmem_read, way_sel}, {3'b000, 2'd2});
        tick();
        check("rmiss_fill", {pmem_read, pmem_write, way_sel}, {1'b1, 1'b0, 2'd2});
        tick();
        check("rmiss_fill_wait", {pmem_read, ld_tag, ld_data}, {1'b1, 8'h00});
        pmem_resp = 1'b1;
        #1;
        check("rmiss_fill_ld", {ld_data, ld_tag, ld_valid, ld_dirty, data_sel, valid_in, dirty_in},
              {4'b0100, 4'b0100, 4'b0100, 4'b0100, 1'b1, 1'b1, 1'b0});
        tick();
        pmem_resp = 1'b0;
        check("rmiss_finish", {mem_resp, ld_plru, way_sel, plru_out, ld_data, pmem_read},
              {1'b1, 1'b1, 2'd2, 3'b100, 4'b0000, 1'b0});
        mem_read = 1'b0;
        tick();
        check("rmiss_idle", {mem_resp, pmem_read}, 32'h0);

        // Write miss with dirty PLRU victim way 0 and a 10-cycle write-back.
        mem_write = 1'b1; valid_vec = 4'b1111; dirty_vec = 4'b0001; plru_in = 3'b000;
        tick();
        tick();
        check("wb_enter", {pmem_write, wb_addr_sel, way_sel, pmem_read}, {1'b1, 1'b1, 2'd0, 1'b0});
        for (int i = 0; i < 10; i++) begin
            if (i == 9) begin
                pmem_resp = 1'b1;
                #1;
                check("wb_resp_ld", {ld_dirty, dirty_in, ld_data, ld_tag}, {4'b0001, 1'b0, 8'h00});
            end
            if (pmem_write) wr_high++;
            if (i < 9 && (|{ld_data, ld_tag, ld_valid, ld_dirty, ld_plru})) ld_seen++;
            tick();
        end
        pmem_resp = 1'b0;
        check("wb_write_cycles", wr_high, 10);
        check("wb_no_early_ld", ld_seen, 0);
        check("wmiss_fill", {pmem_read, pmem_write, wb_addr_sel}, {1'b1, 1'b0, 1'b0});
        pmem_resp = 1'b1;
        #1;
        check("wmiss_fill_ld", {ld_data, ld_tag, data_sel, dirty_in}, {4'b0001, 4'b0001, 1'b1, 1'b0});
        tick();
        pmem_resp = 1'b0;
        check("wmiss_finish", {mem_resp, ld_data, data_sel, dirty_in, ld_dirty, ld_plru, plru_out},
              {1'b1, 4'b0001, 1'b0, 1'b1, 4'b0001, 1'b1, 3'b011});
        mem_write = 1'b0;
        tick();

        // Reset asserted in the middle of a fill.
        mem_read = 1'b1; valid_vec = 4'b0111; dirty_vec = 4'b0000;
        tick();
        tick();
        check("rst_pre_fill", {pmem_read, way_sel}, {1'b1, 2'd3});
        rst_n = 1'b0; pmem_resp = 1'b1;
        #1;
        check("rst_drops_read", {31'h0, pmem_read}, 32'h0);
        check("rst_no_ld", {ld_data, ld_tag, ld_valid, ld_dirty, mem_resp}, 32'h0);
        tick();
        rst_n = 1'b1; pmem_resp = 1'b0; valid_vec = 4'b1111; hit_vec = 4'b0001;
        #1;
        check("post_rst_idle", {mem_resp, pmem_read, ld_plru}, 32'h0);
        tick();
        check("post_rst_hit", {mem_resp, way_sel, plru_out}, {1'b1, 2'd0, 3'b011});
        mem_read = 1'b0; hit_vec = '0;
        tick();
        tick();

        // Back-to-back read hits in every associativity.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        mem_read = 1'b1;
        tick();
        b2b_hit("b2b_a", 4'b0001, 2'b01, 8'h01, 2'd0, 1'b0, 3'd0, 3'b011, 1'b1, 7'b0001011);
        b2b_hit("b2b_b", 4'b0010, 2'b10, 8'h20, 2'd1, 1'b1, 3'd5, 3'b001, 1'b0, 7'b0000100);
        b2b_hit("b2b_c", 4'b1000, 2'b01, 8'h80, 2'd3, 1'b0, 3'd7, 3'b000, 1'b1, 7'b0000000);
        mem_read = 1'b0; hit_vec = '0; hit2 = '0; hit8 = '0;
        #1;
        check("b2b_end", {mem_resp, mem_resp2, mem_resp8}, 32'h0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
